// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the multi-cycle restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Counter width able to hold the iteration count WIDTH.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step_nb.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step_nb #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   partial_rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] dv_mag,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted_s;

  // Trial subtraction on the shifted partial remainder.
  always_comb begin
    shifted_s = {partial_rem, in_bit};
    next_rem  = shifted_s[WIDTH:0];
    q_bit     = 1'b0;
    if (shifted_s >= {2'b00, dv_mag}) begin
      next_rem = shifted_s[WIDTH:0] - {1'b0, dv_mag};
      q_bit    = 1'b1;
    end else begin
      next_rem = shifted_s[WIDTH:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/div_nb.sv
// Multi-cycle signed/unsigned integer divider with valid/ready on both sides.
// Radix-2 restoring division on magnitudes; divide-by-zero and MIN/-1 are resolved up front.
module div_nb
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam int               CNT_W    = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement negation, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  div_state_t       state_r, state_s;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] op_dd_r, op_dv_r;
  logic             signed_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0] quo_r, dvm_r;
  logic [WIDTH:0]   rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dbz_r, ovf_r;
  logic [WIDTH-1:0] res_q_r, res_r_r;

  logic             dd_neg_s, dv_neg_s, dv_zero_s, ovf_hit_s;
  logic [WIDTH:0]   next_rem_s;
  logic             q_bit_s;

  assign dd_neg_s  = signed_r & op_dd_r[WIDTH-1];
  assign dv_neg_s  = signed_r & op_dv_r[WIDTH-1];
  assign dv_zero_s = (op_dv_r == ZERO_W);
  assign ovf_hit_s = signed_r & (op_dd_r == MIN_W) & (op_dv_r == ONES_W);

  div_step_nb #(.WIDTH(WIDTH)) u_step (
    .partial_rem (rem_r),
    .in_bit      (quo_r[WIDTH-1]),
    .dv_mag      (dvm_r),
    .next_rem    (next_rem_s),
    .q_bit       (q_bit_s)
  );

  // Next-state decode; special results still pass through FIX so results load in one place.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid_i) state_s = PREP;
        else            state_s = IDLE;
      end
      PREP: begin
        if (dv_zero_s | ovf_hit_s) state_s = FIX;
        else                       state_s = CALC;
      end
      CALC: begin
        if (cnt_r == CNT_LAST) state_s = FIX;
        else                   state_s = CALC;
      end
      FIX:  state_s = DONE;
      DONE: begin
        if (out_ready_i) state_s = IDLE;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_dd_r  <= ZERO_W;
      op_dv_r  <= ZERO_W;
      signed_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      quo_r    <= ZERO_W;
      dvm_r    <= ZERO_W;
      rem_r    <= {1'b0, ZERO_W};
      cnt_r    <= CNT_ZERO;
      dbz_r    <= 1'b0;
      ovf_r    <= 1'b0;
      res_q_r  <= ZERO_W;
      res_r_r  <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            op_dd_r  <= dividend_i;
            op_dv_r  <= divisor_i;
            signed_r <= signed_i;
          end
        end
        PREP: begin
          neg_q_r <= dd_neg_s ^ dv_neg_s;
          neg_r_r <= dd_neg_s;
          quo_r   <= dd_neg_s ? neg_w(op_dd_r) : op_dd_r;
          dvm_r   <= dv_neg_s ? neg_w(op_dv_r) : op_dv_r;
          rem_r   <= {1'b0, ZERO_W};
          cnt_r   <= CNT_ZERO;
          dbz_r   <= dv_zero_s;
          ovf_r   <= ~dv_zero_s & ovf_hit_s;
        end
        CALC: begin
          quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
          rem_r <= next_rem_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          if (dbz_r) begin
            res_q_r <= ONES_W;
            res_r_r <= op_dd_r;
          end else if (ovf_r) begin
            res_q_r <= op_dd_r;
            res_r_r <= ZERO_W;
          end else begin
            res_q_r <= neg_q_r ? neg_w(quo_r) : quo_r;
            res_r_r <= neg_r_r ? neg_w(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign quotient_o  = res_q_r;
  assign remainder_o = res_r_r;
  assign dbz_o       = dbz_r;
  assign ovf_o       = ovf_r;

endmodule

// File: tb/tb_div_nb.sv
// Self-checking bench for div_nb at WIDTH=8 and WIDTH=64 against an arithmetic reference model.
module tb_div_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic       iv8, ir8, s8, ov8, or8, dbz8, ovf8;
  logic [7:0] dd8, dv8, q8, r8;
  logic        iv64, ir64, s64, ov64, or64, dbz64, ovf64;
  logic [63:0] dd64, dv64, q64, r64;

  div_nb #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8), .signed_i(s8),
    .dividend_i(dd8), .divisor_i(dv8), .out_valid_o(ov8), .out_ready_i(or8),
    .quotient_o(q8), .remainder_o(r8), .dbz_o(dbz8), .ovf_o(ovf8)
  );

  div_nb #(.WIDTH(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv64), .in_ready_o(ir64), .signed_i(s64),
    .dividend_i(dd64), .divisor_i(dv64), .out_valid_o(ov64), .out_ready_i(or64),
    .quotient_o(q64), .remainder_o(r64), .dbz_o(dbz64), .ovf_o(ovf64)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref8(input logic s, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] q, output logic [7:0] r,
                               output logic dbz, output logic ovf);
    int sa, sb;
    dbz = (b == 8'h00);
    ovf = s && !dbz && (a == 8'h80) && (b == 8'hFF);
    q = 8'h00;
    r = 8'h00;
    if (dbz) begin
      q = 8'hFF; r = a;
    end else if (ovf) begin
      q = a; r = 8'h00;
    end else begin
      sa = s ? int'($signed(a)) : int'({24'd0, a});
      sb = s ? int'($signed(b)) : int'({24'd0, b});
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
  endfunction

  function automatic void ref64(input logic s, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r,
                                output logic dbz, output logic ovf);
    longint sa, sb;
    dbz = (b == 64'd0);
    ovf = s && !dbz && (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    q = 64'd0;
    r = 64'd0;
    if (dbz) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
    end else if (ovf) begin
      q = a; r = 64'd0;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic early,
                     output logic [7:0] qo, output logic [7:0] ro);
    logic [7:0] eq, er;
    logic       ed, eo;
    int         lat, exp_lat;
    ref8(s, a, b, eq, er, ed, eo);
    exp_lat = (ed || eo) ? 2 : 10;
    @(negedge clk);
    chk("rdy8_idle", 128'(ir8), 128'(1'b1));
    iv8 = 1'b1; s8 = s; dd8 = a; dv8 = b; or8 = early;
    @(posedge clk); #1;
    iv8 = 1'b0; s8 = 1'($urandom); dd8 = 8'($urandom); dv8 = 8'($urandom);
    chk("rdy8_busy", 128'(ir8), 128'(1'b0));
    lat = 0;
    while (ov8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat8", 128'(lat), 128'(exp_lat));
    chk("q8", 128'(q8), 128'(eq));
    chk("r8", 128'(r8), 128'(er));
    chk("dbz8", 128'(dbz8), 128'(ed));
    chk("ovf8", 128'(ovf8), 128'(eo));
    qo = q8;
    ro = r8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("vld8_after", 128'(ov8), 128'(1'b0));
    chk("rdy8_after", 128'(ir8), 128'(1'b1));
  endtask

  task automatic op64(input logic s, input logic [63:0] a, input logic [63:0] b, input int hold,
                      output logic [63:0] qo, output logic [63:0] ro);
    logic [63:0] eq, er;
    logic        ed, eo;
    int          lat, exp_lat;
    ref64(s, a, b, eq, er, ed, eo);
    exp_lat = (ed || eo) ? 2 : 66;
    @(negedge clk);
    chk("rdy64_idle", 128'(ir64), 128'(1'b1));
    iv64 = 1'b1; s64 = s; dd64 = a; dv64 = b; or64 = 1'b0;
    @(posedge clk); #1;
    iv64 = 1'b0; s64 = 1'($urandom); dd64 = {$urandom, $urandom}; dv64 = {$urandom, $urandom};
    lat = 0;
    while (ov64 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat64", 128'(lat), 128'(exp_lat));
    // Backpressure: offer a competing operation while the result is held.
    for (int i = 0; i < hold; i++) begin
      iv64 = 1'b1; dd64 = {$urandom, $urandom}; dv64 = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp64_vld", 128'(ov64), 128'(1'b1));
      chk("bp64_rdy", 128'(ir64), 128'(1'b0));
      chk("bp64_q", 128'(q64), 128'(eq));
      chk("bp64_r", 128'(r64), 128'(er));
    end
    iv64 = 1'b0;
    chk("q64", 128'(q64), 128'(eq));
    chk("r64", 128'(r64), 128'(er));
    chk("dbz64", 128'(dbz64), 128'(ed));
    chk("ovf64", 128'(ovf64), 128'(eo));
    qo = q64;
    ro = r64;
    or64 = 1'b1;
    @(posedge clk); #1;
    or64 = 1'b0;
    chk("vld64_after", 128'(ov64), 128'(1'b0));
    chk("rdy64_after", 128'(ir64), 128'(1'b1));
    @(posedge clk); #1;
    chk("vld64_quiet", 128'(ov64), 128'(1'b0));
  endtask

  initial begin
    logic [7:0]  a8, b8, qd8, rd8;
    logic [63:0] a64, b64, qd64, rd64;
    logic        sg, er;
    int          sel;

    rst = 1'b1;
    iv8 = 1'b0; s8 = 1'b0; dd8 = 8'h00; dv8 = 8'h00; or8 = 1'b0;
    iv64 = 1'b0; s64 = 1'b0; dd64 = 64'd0; dv64 = 64'd0; or64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst8_rdy", 128'(ir8), 128'(1'b1));
    chk("rst8_vld", 128'(ov8), 128'(1'b0));
    chk("rst8_q", 128'(q8), 128'(8'h00));
    chk("rst8_r", 128'(r8), 128'(8'h00));
    chk("rst8_flags", 128'({dbz8, ovf8}), 128'(2'b00));
    chk("rst64_rdy", 128'(ir64), 128'(1'b1));
    chk("rst64_vld", 128'(ov64), 128'(1'b0));
    rst = 1'b0;

    op8(1'b0, 8'd200, 8'd7, 1'b0, qd8, rd8);
    chk("u200_7_q", 128'(qd8), 128'(8'd28));
    chk("u200_7_r", 128'(rd8), 128'(8'd4));
    op8(1'b1, 8'hF9, 8'h02, 1'b0, qd8, rd8);
    chk("sm7_2_q", 128'(qd8), 128'(8'hFD));
    chk("sm7_2_r", 128'(rd8), 128'(8'hFF));
    op8(1'b1, 8'h07, 8'hFE, 1'b1, qd8, rd8);
    chk("s7_m2_q", 128'(qd8), 128'(8'hFD));
    chk("s7_m2_r", 128'(rd8), 128'(8'h01));
    op8(1'b0, 8'h5A, 8'h00, 1'b0, qd8, rd8);
    chk("udbz_q", 128'(qd8), 128'(8'hFF));
    chk("udbz_r", 128'(rd8), 128'(8'h5A));
    op8(1'b1, 8'h5A, 8'h00, 1'b0, qd8, rd8);
    chk("sdbz_q", 128'(qd8), 128'(8'hFF));
    op8(1'b1, 8'h80, 8'hFF, 1'b0, qd8, rd8);
    chk("sovf_q", 128'(qd8), 128'(8'h80));
    chk("sovf_r", 128'(rd8), 128'(8'h00));
    op8(1'b0, 8'h80, 8'hFF, 1'b1, qd8, rd8);
    chk("uovf_q", 128'(qd8), 128'(8'h00));
    chk("uovf_r", 128'(rd8), 128'(8'h80));

    repeat (60) begin
      sel = int'($urandom_range(0, 7));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (sel == 0) b8 = 8'h00;
      if (sel == 1) begin a8 = 8'h80; b8 = 8'hFF; end
      sg = 1'($urandom);
      er = 1'($urandom);
      op8(sg, a8, b8, er, qd8, rd8);
    end

    op64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5, qd64, rd64);
    chk("u64max_3_q", 128'(qd64), 128'(64'h5555_5555_5555_5555));
    chk("u64max_3_r", 128'(rd64), 128'(64'd0));

    // Reset while an operation is iterating.
    @(negedge clk);
    iv64 = 1'b1; s64 = 1'b0; dd64 = 64'd100; dv64 = 64'd10;
    @(posedge clk); #1;
    iv64 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midop_busy", 128'(ir64), 128'(1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_rdy", 128'(ir64), 128'(1'b1));
    chk("midrst_vld", 128'(ov64), 128'(1'b0));
    chk("midrst_q", 128'(q64), 128'(64'd0));
    chk("midrst_r", 128'(r64), 128'(64'd0));
    chk("midrst_flags", 128'({dbz64, ovf64}), 128'(2'b00));
    op64(1'b0, 64'd100, 64'd10, 0, qd64, rd64);
    chk("u100_10_q", 128'(qd64), 128'(64'd10));
    chk("u100_10_r", 128'(rd64), 128'(64'd0));

    op64(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, qd64, rd64);
    op64(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'd7, 0, qd64, rd64);
    repeat (12) begin
      sel = int'($urandom_range(0, 5));
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      if (sel == 0) b64 = 64'd0;
      if (sel == 1) b64 = {32'd0, $urandom};
      sg = 1'($urandom);
      op64(sg, a64, b64, int'($urandom_range(0, 2)), qd64, rd64);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
